// File: rtl/mmio_data_memory.sv
// mmio_data_memory: word-addressed RAM with byte-lane writes plus a small
// memory-mapped I/O bank (LED/HEX outputs, synchronised switches and keys,
// sticky key-press capture, countdown timer with interrupt).
// Read data is registered: dOut is valid one cycle after addr is presented.
module mmio_data_memory #(
  parameter              MEM_INIT_FILE       = "",
  parameter int unsigned ADDR_BIT_WIDTH      = 32,
  parameter int unsigned DATA_BIT_WIDTH      = 32,
  parameter int unsigned TRUE_ADDR_BIT_WIDTH = 11,
  parameter int unsigned IO_SEL_BIT          = 29,
  parameter int unsigned N_SW                = 10,
  parameter int unsigned N_KEY               = 4,
  parameter int unsigned N_LED               = 10,
  parameter int unsigned HEX_BITS            = 16,
  parameter int unsigned TIMER_PRESCALE      = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wrtEn,
  input  logic [DATA_BIT_WIDTH/8-1:0] byteEn,
  input  logic [ADDR_BIT_WIDTH-1:0]   addr,
  input  logic [DATA_BIT_WIDTH-1:0]   dIn,
  input  logic [N_SW-1:0]             sw,
  input  logic [N_KEY-1:0]            key,
  output logic [N_LED-1:0]            ledr,
  output logic [HEX_BITS-1:0]         hex,
  output logic [DATA_BIT_WIDTH-1:0]   dOut,
  output logic                        irq
);

  localparam int unsigned N_WORDS = 1 << TRUE_ADDR_BIT_WIDTH;
  localparam int unsigned N_BYTES = DATA_BIT_WIDTH / 8;
  localparam int unsigned PW      = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_PRESCALE - 1);
  localparam logic [DATA_BIT_WIDTH-1:0] ONE = DATA_BIT_WIDTH'(1);

  logic [DATA_BIT_WIDTH-1:0] mem_q [N_WORDS];

  logic                           io_sel, ram_we, io_we;
  logic [TRUE_ADDR_BIT_WIDTH-1:0] ram_idx;
  logic [2:0]                     io_off;
  logic                           wr_hex, wr_ledr, wr_kedge, wr_load, wr_ctrl;
  logic                           tick, expire;
  logic [N_KEY-1:0]               key_rise;
  logic [DATA_BIT_WIDTH-1:0]      io_rdata;
  logic                           unused_addr_bits;

  logic [HEX_BITS-1:0]       hex_q, hex_d;
  logic [N_LED-1:0]          ledr_q, ledr_d;
  logic [N_SW-1:0]           sw_s1_q, sw_s2_q;
  logic [N_KEY-1:0]          key_s1_q, key_s2_q, key_s3_q;
  logic [N_KEY-1:0]          kedge_q, kedge_d;
  logic [DATA_BIT_WIDTH-1:0] load_q, load_d, count_q, count_d, dout_q, dout_d;
  logic                      en_q, en_d, auto_q, auto_d, ie_q, ie_d, exp_q, exp_d;
  logic [PW-1:0]             presc_q, presc_d;
  logic                      irq_q;

  // Bits between the RAM index and the I/O select are deliberately ignored
  // (addresses wrap), as are the byte-offset bits.
  assign unused_addr_bits = ^addr;

  assign io_sel  = addr[IO_SEL_BIT];
  assign ram_idx = addr[TRUE_ADDR_BIT_WIDTH+1:2];
  assign io_off  = addr[4:2];
  assign ram_we  = wrtEn & ~io_sel & ~reset;
  assign io_we   = wrtEn & io_sel;

  assign wr_hex   = io_we & (io_off == 3'd0);
  assign wr_ledr  = io_we & (io_off == 3'd1);
  assign wr_kedge = io_we & (io_off == 3'd4);
  assign wr_load  = io_we & (io_off == 3'd5);
  assign wr_ctrl  = io_we & (io_off == 3'd7);

  // I/O read mux; narrower registers are zero-extended.
  always_comb begin
    io_rdata = '0;
    unique case (io_off)
      3'd0: io_rdata = DATA_BIT_WIDTH'(hex_q);
      3'd1: io_rdata = DATA_BIT_WIDTH'(ledr_q);
      3'd2: io_rdata = DATA_BIT_WIDTH'(sw_s2_q);
      3'd3: io_rdata = DATA_BIT_WIDTH'(key_s2_q);
      3'd4: io_rdata = DATA_BIT_WIDTH'(kedge_q);
      3'd5: io_rdata = load_q;
      3'd6: io_rdata = count_q;
      3'd7: io_rdata = DATA_BIT_WIDTH'({exp_q, ie_q, auto_q, en_q});
      default: io_rdata = '0;
    endcase
  end

  // Next-state for I/O registers and timer; hardware sets win over W1C,
  // a LOAD write supersedes a tick in the same cycle.
  always_comb begin
    hex_d    = hex_q;
    ledr_d   = ledr_q;
    load_d   = load_q;
    count_d  = count_q;
    en_d     = en_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    presc_d  = presc_q;
    expire   = 1'b0;
    key_rise = key_s2_q & ~key_s3_q;
    tick     = en_q & (presc_q == PRESC_LAST);

    if (wr_hex)  hex_d  = dIn[HEX_BITS-1:0];
    if (wr_ledr) ledr_d = dIn[N_LED-1:0];

    kedge_d = key_rise | (kedge_q & ~(wr_kedge ? dIn[N_KEY-1:0] : '0));

    if (!en_q || tick) presc_d = '0;
    else               presc_d = presc_q + 1'b1;

    if (wr_load) begin
      load_d  = dIn;
      count_d = dIn;
    end else if (tick) begin
      if (count_q == ONE) begin
        expire  = 1'b1;
        count_d = auto_q ? load_q : '0;
      end else if (count_q != '0) begin
        count_d = count_q - ONE;
      end
    end

    if (wr_ctrl) begin
      en_d   = dIn[0];
      auto_d = dIn[1];
      ie_d   = dIn[2];
    end
    exp_d = expire | (exp_q & ~(wr_ctrl & dIn[3]));

    dout_d = io_sel ? io_rdata : mem_q[ram_idx];
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < N_BYTES; b++) begin
        if (byteEn[b]) mem_q[ram_idx][b*8 +: 8] <= dIn[b*8 +: 8];
      end
    end
  end

  // Register bank, synchronisers, timer and read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q    <= '0;
      ledr_q   <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '0;
      key_s2_q <= '0;
      key_s3_q <= '0;
      kedge_q  <= '0;
      load_q   <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      exp_q    <= 1'b0;
      presc_q  <= '0;
      irq_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      hex_q    <= hex_d;
      ledr_q   <= ledr_d;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= ~key;
      key_s2_q <= key_s1_q;
      key_s3_q <= key_s2_q;
      kedge_q  <= kedge_d;
      load_q   <= load_d;
      count_q  <= count_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      exp_q    <= exp_d;
      presc_q  <= presc_d;
      irq_q    <= ie_q & exp_q;
      dout_q   <= dout_d;
    end
  end

  assign hex  = hex_q;
  assign ledr = ledr_q;
  assign dOut = dout_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_mmio_data_memory.sv
// Directed bench for mmio_data_memory with default parameters.
module tb_mmio_data_memory;

  localparam logic [31:0] IO      = 32'h2000_0000;
  localparam logic [31:0] A_HEX   = IO + 32'd0;
  localparam logic [31:0] A_LEDR  = IO + 32'd4;
  localparam logic [31:0] A_SW    = IO + 32'd8;
  localparam logic [31:0] A_KEY   = IO + 32'd12;
  localparam logic [31:0] A_KEDGE = IO + 32'd16;
  localparam logic [31:0] A_LOAD  = IO + 32'd20;
  localparam logic [31:0] A_COUNT = IO + 32'd24;
  localparam logic [31:0] A_CTRL  = IO + 32'd28;

  logic        clk = 1'b0;
  logic        reset, wrtEn;
  logic [3:0]  byteEn;
  logic [31:0] addr, dIn, dOut;
  logic [9:0]  sw, ledr;
  logic [3:0]  key;
  logic [15:0] hex;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] r;

  mmio_data_memory dut (
    .clk    (clk),
    .reset  (reset),
    .wrtEn  (wrtEn),
    .byteEn (byteEn),
    .addr   (addr),
    .dIn    (dIn),
    .sw     (sw),
    .key    (key),
    .ledr   (ledr),
    .hex    (hex),
    .dOut   (dOut),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; dIn = d; byteEn = be; wrtEn = 1'b1;
    step();
    wrtEn = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; wrtEn = 1'b0;
    step();
    d = dOut;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wrtEn = 1'b0; byteEn = '0; addr = '0; dIn = '0;
    sw = '0; key = 4'hF;
    step(); step();
    check("rst_ledr", 32'(ledr), 32'h0);
    check("rst_hex",  32'(hex),  32'h0);
    check("rst_dout", dOut,      32'h0);
    check("rst_irq",  32'(irq),  32'h0);
    reset = 1'b0;
    rd(A_CTRL, r);  check("rst_ctrl",  r, 32'h0);
    rd(A_COUNT, r); check("rst_count", r, 32'h0);

    // byte lanes
    wr(32'd20, 32'h1122_3344, 4'b1111);
    wr(32'd20, 32'hAABB_CCDD, 4'b0101);
    rd(32'd20, r); check("ram_byteen", r, 32'h11BB_33DD);

    // wrap modulo N_WORDS
    wr((32'd2048 + 32'd3) * 4, 32'h0000_CAFE, 4'b1111);
    rd(32'd12, r); check("ram_wrap", r, 32'h0000_CAFE);

    // read-before-write on the same word
    wr(32'd20, 32'h0, 4'b1111);
    check("ram_rbw_old", dOut, 32'h11BB_33DD);
    rd(32'd20, r); check("ram_rbw_new", r, 32'h0);

    // output registers and reset override
    wr(A_LEDR, 32'h3FF, 4'b0000);
    wr(A_HEX, 32'hBEEF, 4'b0000);
    check("ledr_out", 32'(ledr), 32'h3FF);
    check("hex_out",  32'(hex),  32'hBEEF);
    rd(A_HEX, r); check("hex_read", r, 32'hBEEF);
    wr(A_LEDR, 32'hFFFF_FC00, 4'b1111);
    check("ledr_trunc", 32'(ledr), 32'h0);
    wr(A_LEDR, 32'h3FF, 4'b1111);
    reset = 1'b1; addr = A_LEDR; dIn = 32'h155; wrtEn = 1'b1;
    step();
    reset = 1'b0; wrtEn = 1'b0;
    check("reset_ledr", 32'(ledr), 32'h0);
    check("reset_hex",  32'(hex),  32'h0);
    check("reset_dout", dOut,      32'h0);
    rd(32'd12, r); check("ram_keep_reset", r, 32'h0000_CAFE);

    // switches
    sw = 10'h2A5;
    step(); step();
    rd(A_SW, r); check("sw_sync", r, 32'h2A5);
    wr(A_SW, 32'h0, 4'b1111);
    rd(A_SW, r); check("sw_ro", r, 32'h2A5);

    // key capture
    key = 4'b1011; step(); key = 4'hF; step(); step(); step();
    rd(A_KEDGE, r); check("kedge_press1", r, 32'h4);
    key = 4'b1011; step(); key = 4'hF; step(); step(); step();
    rd(A_KEDGE, r); check("kedge_press2", r, 32'h4);
    wr(A_KEDGE, 32'h4, 4'b0000);
    rd(A_KEDGE, r); check("kedge_w1c", r, 32'h0);
    key = 4'b1011; step(); key = 4'hF; step();
    wr(A_KEDGE, 32'h4, 4'b0000);
    rd(A_KEDGE, r); check("kedge_set_wins", r, 32'h4);
    key = 4'b1110; step(); step();
    rd(A_KEY, r);   check("key_pressed", r, 32'h1);
    rd(A_KEDGE, r); check("kedge_bit0", r, 32'h5);
    key = 4'hF;

    // one-shot timer
    wr(A_LOAD, 32'd3, 4'b1111);
    wr(A_CTRL, 32'h5, 4'b1111);
    rd(A_COUNT, r); check("os_cnt3", r, 32'd3);
    check("os_irq_a1", 32'(irq), 32'h0);
    rd(A_COUNT, r); check("os_cnt2", r, 32'd2);
    rd(A_COUNT, r); check("os_cnt1", r, 32'd1);
    check("os_irq_a3", 32'(irq), 32'h0);
    rd(A_CTRL, r);  check("os_exp", r, 32'hD);
    check("os_irq_rise", 32'(irq), 32'h1);
    rd(A_COUNT, r); check("os_cnt0", r, 32'd0);
    wr(A_CTRL, 32'hD, 4'b1111);
    check("os_irq_hold", 32'(irq), 32'h1);
    step();
    check("os_irq_drop", 32'(irq), 32'h0);
    rd(A_CTRL, r);  check("os_ctrl_w1c", r, 32'h5);

    // auto-reload timer
    wr(A_CTRL, 32'h0, 4'b1111);
    wr(A_LOAD, 32'd2, 4'b1111);
    wr(A_CTRL, 32'h7, 4'b1111);
    rd(A_COUNT, r); check("ar_seq0", r, 32'd2);
    rd(A_COUNT, r); check("ar_seq1", r, 32'd1);
    rd(A_COUNT, r); check("ar_seq2", r, 32'd2);
    rd(A_COUNT, r); check("ar_seq3", r, 32'd1);
    wr(A_LOAD, 32'd5, 4'b1111);
    rd(A_COUNT, r); check("ar_load_wins", r, 32'd5);
    rd(A_CTRL, r);  check("ar_exp", r, 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
